// File: rtl/seed_laser_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : seed_laser_sequencer
// Purpose  : Seed laser power-up/shutdown sequencer with DAC load handshake
//            and debounced over-current interlock. Optional build macro
//            SEED_SEQ_AUTO_RETRY_EN adds a timed auto-retry out of FAULT.
// Revision : 1.0 - initial release
// ============================================================================
module seed_laser_sequencer #(
    parameter int SETTLE_CYCLES = 10000,
    parameter int OC_DEBOUNCE   = 3,
    parameter int DAC_TIMEOUT   = 4096
`ifdef SEED_SEQ_AUTO_RETRY_EN
    ,
    parameter int RETRY_DELAY   = 100000,
    parameter int RETRY_MAX     = 3
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_req,
    input  logic        fault_clear,
    input  logic [15:0] current_limit,
    input  logic        adc_data_valid,
    input  logic [15:0] adc_current_data,
    input  logic        dac_busy,
    output logic        dac_limit_update,
    output logic        dac_gain_update,
    output logic        laser_enable,
    output logic        over_current,
    output logic [1:0]  fault_cause,
    output logic [7:0]  fault_count,
    output logic [2:0]  seq_state
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_LIM_REQ   = 3'd1;
    localparam logic [2:0] c_LIM_WAIT  = 3'd2;
    localparam logic [2:0] c_GAIN_REQ  = 3'd3;
    localparam logic [2:0] c_GAIN_WAIT = 3'd4;
    localparam logic [2:0] c_SETTLE    = 3'd5;
    localparam logic [2:0] c_RUN       = 3'd6;
    localparam logic [2:0] c_FAULT     = 3'd7;

    localparam logic [1:0] c_CAUSE_NONE = 2'd0;
    localparam logic [1:0] c_CAUSE_OC   = 2'd1;
    localparam logic [1:0] c_CAUSE_DAC  = 2'd2;

    localparam int c_SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int c_TMO_W    = $clog2(DAC_TIMEOUT + 1);
    localparam int c_OC_W     = $clog2(OC_DEBOUNCE + 1);

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic [c_TMO_W-1:0]    r_wait_cnt;
    logic [c_SETTLE_W-1:0] r_settle_cnt;
    logic [c_OC_W-1:0]     r_oc_cnt;
    logic                  r_busy_seen;
    logic                  r_dac_limit_update;
    logic                  r_dac_gain_update;
    logic                  r_laser_enable;
    logic                  r_over_current;
    logic [1:0]            r_fault_cause;
    logic [7:0]            r_fault_count;

    logic w_in_dac;
    logic w_timeout;
    logic w_over;
    logic w_trip;

    assign w_in_dac  = (r_state >= c_LIM_REQ) && (r_state <= c_GAIN_WAIT);
    assign w_timeout = w_in_dac && (r_wait_cnt == c_TMO_W'(DAC_TIMEOUT - 1));
    assign w_over    = adc_data_valid && (adc_current_data > current_limit);
    assign w_trip    = (r_state == c_RUN) && w_over && (r_oc_cnt == c_OC_W'(OC_DEBOUNCE - 1));

`ifdef SEED_SEQ_AUTO_RETRY_EN
    localparam int         c_RETRY_W   = $clog2(RETRY_DELAY + 1);
    localparam logic [7:0] c_RETRY_MAX = 8'(RETRY_MAX);

    logic [c_RETRY_W-1:0] r_retry_cnt;
    logic                 w_retry_ok;
    logic                 w_retry_go;

    // Retry budget is judged on the already-incremented fault count.
    assign w_retry_ok = (r_state == c_FAULT) && enable_req && (r_fault_count <= c_RETRY_MAX);
    assign w_retry_go = w_retry_ok && (r_retry_cnt == c_RETRY_W'(RETRY_DELAY - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retry_cnt <= '0;
        end else if (w_retry_ok && !w_retry_go) begin
            r_retry_cnt <= r_retry_cnt + 1'b1;
        end else begin
            r_retry_cnt <= '0;
        end
    end
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:      if (enable_req) w_next = c_LIM_REQ;
            c_LIM_REQ:   if (!dac_busy) w_next = c_LIM_WAIT;
            c_LIM_WAIT:  if (r_busy_seen && !dac_busy) w_next = c_GAIN_REQ;
            c_GAIN_REQ:  if (!dac_busy) w_next = c_GAIN_WAIT;
            c_GAIN_WAIT: if (r_busy_seen && !dac_busy) w_next = c_SETTLE;
            c_SETTLE:    if (r_settle_cnt == c_SETTLE_W'(SETTLE_CYCLES - 1)) w_next = c_RUN;
            c_RUN:       w_next = c_RUN;
            c_FAULT: begin
                if (fault_clear && !enable_req) begin
                    w_next = c_IDLE;
                end
`ifdef SEED_SEQ_AUTO_RETRY_EN
                else if (w_retry_go) begin
                    w_next = c_LIM_REQ;
                end
`endif
            end
        endcase
        // Request drop aborts the sequence, but a fault in the same cycle wins.
        if (!enable_req && (r_state != c_FAULT)) w_next = c_IDLE;
        if (w_timeout || w_trip) w_next = c_FAULT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state            <= c_IDLE;
            r_wait_cnt         <= '0;
            r_settle_cnt       <= '0;
            r_oc_cnt           <= '0;
            r_busy_seen        <= 1'b0;
            r_dac_limit_update <= 1'b0;
            r_dac_gain_update  <= 1'b0;
            r_laser_enable     <= 1'b0;
            r_over_current     <= 1'b0;
            r_fault_cause      <= c_CAUSE_NONE;
            r_fault_count      <= 8'd0;
        end else begin
            r_state            <= w_next;
            r_dac_limit_update <= (r_state == c_LIM_REQ)  && (w_next == c_LIM_WAIT);
            r_dac_gain_update  <= (r_state == c_GAIN_REQ) && (w_next == c_GAIN_WAIT);
            r_laser_enable     <= (w_next == c_RUN);

            // One timeout budget covers a REQ state and its following WAIT state.
            if (((w_next == c_LIM_REQ) && (r_state != c_LIM_REQ)) ||
                ((w_next == c_GAIN_REQ) && (r_state != c_GAIN_REQ))) begin
                r_wait_cnt <= '0;
            end else if (w_in_dac) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            if (w_next != r_state) begin
                r_busy_seen <= 1'b0;
            end else if (dac_busy) begin
                r_busy_seen <= 1'b1;
            end

            if (r_state == c_SETTLE) begin
                r_settle_cnt <= r_settle_cnt + 1'b1;
            end else begin
                r_settle_cnt <= '0;
            end

            if ((r_state == c_RUN) && (w_next == c_RUN)) begin
                if (adc_data_valid) begin
                    r_oc_cnt <= w_over ? (r_oc_cnt + 1'b1) : '0;
                end
            end else begin
                r_oc_cnt <= '0;
            end

            if ((w_next == c_FAULT) && (r_state != c_FAULT)) begin
                r_over_current <= 1'b1;
                r_fault_cause  <= w_trip ? c_CAUSE_OC : c_CAUSE_DAC;
                if (r_fault_count != 8'hFF) r_fault_count <= r_fault_count + 8'd1;
            end else if ((r_state == c_FAULT) && (w_next != c_FAULT)) begin
                r_over_current <= 1'b0;
                r_fault_cause  <= c_CAUSE_NONE;
            end
        end
    end

    assign dac_limit_update = r_dac_limit_update;
    assign dac_gain_update  = r_dac_gain_update;
    assign laser_enable     = r_laser_enable;
    assign over_current     = r_over_current;
    assign fault_cause      = r_fault_cause;
    assign fault_count      = r_fault_count;
    assign seq_state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_seed_laser_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_seed_laser_sequencer
// Purpose  : Directed, self-checking bench for seed_laser_sequencer with a
//            cycle-level reference model; retry scenario under
//            SEED_SEQ_AUTO_RETRY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seed_laser_sequencer;

    localparam int c_SETTLE    = 20;
    localparam int c_OC        = 3;
    localparam int c_TIMEOUT   = 50;
    localparam int c_RETRY_DLY = 30;
    localparam int c_RETRY_MAX = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable_req = 1'b0;
    logic        fault_clear = 1'b0;
    logic [15:0] current_limit = 16'h8000;
    logic        adc_data_valid = 1'b0;
    logic [15:0] adc_current_data = 16'h0000;
    logic        dac_busy;
    logic        dac_limit_update;
    logic        dac_gain_update;
    logic        laser_enable;
    logic        over_current;
    logic [1:0]  fault_cause;
    logic [7:0]  fault_count;
    logic [2:0]  seq_state;

    logic force_busy = 1'b0;
    logic auto_busy;
    int   busy_left;
    int   lim_pulses = 0;
    int   gain_pulses = 0;
    int   checks = 0;
    int   errors = 0;

    assign dac_busy = force_busy | auto_busy;

    seed_laser_sequencer #(
        .SETTLE_CYCLES(c_SETTLE),
        .OC_DEBOUNCE  (c_OC),
        .DAC_TIMEOUT  (c_TIMEOUT)
`ifdef SEED_SEQ_AUTO_RETRY_EN
        ,
        .RETRY_DELAY  (c_RETRY_DLY),
        .RETRY_MAX    (c_RETRY_MAX)
`endif
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable_req      (enable_req),
        .fault_clear     (fault_clear),
        .current_limit   (current_limit),
        .adc_data_valid  (adc_data_valid),
        .adc_current_data(adc_current_data),
        .dac_busy        (dac_busy),
        .dac_limit_update(dac_limit_update),
        .dac_gain_update (dac_gain_update),
        .laser_enable    (laser_enable),
        .over_current    (over_current),
        .fault_cause     (fault_cause),
        .fault_count     (fault_count),
        .seq_state       (seq_state)
    );

    always #5 clk = ~clk;

    // DAC SPI stand-in: busy for four cycles after each load pulse.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            busy_left <= 0;
            auto_busy <= 1'b0;
        end else if (dac_limit_update || dac_gain_update) begin
            busy_left <= 3;
            auto_busy <= 1'b1;
        end else begin
            auto_busy <= (busy_left > 0);
            if (busy_left > 0) busy_left <= busy_left - 1;
        end
    end

    always @(negedge clk) begin
        if (dac_limit_update) lim_pulses  <= lim_pulses + 1;
        if (dac_gain_update)  gain_pulses <= gain_pulses + 1;
    end

    // Reference model: phase number plus elapsed/remaining timers.
    typedef struct packed {
        int st;
        int dac_age;
        bit seen;
        int settle_left;
        int streak;
        int retry_age;
        bit laser;
        bit oc;
        int cause;
        int count;
        bit lp;
        bit gp;
    } model_t;

    model_t m;

    function automatic model_t step(model_t cur);
        model_t n;
        bit trip;
        bit tmo;
        n = cur;
        n.lp = 1'b0;
        n.gp = 1'b0;
        trip = 1'b0;
        tmo = 1'b0;
        case (cur.st)
            0: if (enable_req) begin n.st = 1; n.dac_age = 0; end
            1, 3: begin
                n.dac_age = cur.dac_age + 1;
                if (n.dac_age >= c_TIMEOUT) tmo = 1'b1;
                else if (!dac_busy) begin
                    n.st = cur.st + 1;
                    n.seen = 1'b0;
                    if (cur.st == 1) n.lp = 1'b1; else n.gp = 1'b1;
                end
            end
            2, 4: begin
                n.dac_age = cur.dac_age + 1;
                if (n.dac_age >= c_TIMEOUT) tmo = 1'b1;
                else if (dac_busy) n.seen = 1'b1;
                else if (cur.seen) begin
                    n.st = cur.st + 1;
                    n.dac_age = 0;
                    n.seen = 1'b0;
                    if (cur.st == 4) n.settle_left = c_SETTLE;
                end
            end
            5: begin
                n.settle_left = cur.settle_left - 1;
                if (n.settle_left == 0) n.st = 6;
            end
            6: if (adc_data_valid) begin
                if (adc_current_data > current_limit) begin
                    n.streak = cur.streak + 1;
                    if (n.streak >= c_OC) trip = 1'b1;
                end else begin
                    n.streak = 0;
                end
            end
            default: begin
                if (fault_clear && !enable_req) begin
                    n.st = 0; n.oc = 1'b0; n.cause = 0; n.retry_age = 0;
                end
`ifdef SEED_SEQ_AUTO_RETRY_EN
                else if (enable_req && cur.count <= c_RETRY_MAX) begin
                    n.retry_age = cur.retry_age + 1;
                    if (n.retry_age >= c_RETRY_DLY) begin
                        n.st = 1; n.dac_age = 0; n.oc = 1'b0; n.cause = 0; n.retry_age = 0;
                    end
                end else begin
                    n.retry_age = 0;
                end
`endif
            end
        endcase
        if (!enable_req && cur.st != 7) begin
            n.st = 0; n.lp = 1'b0; n.gp = 1'b0;
        end
        if (trip || tmo) begin
            n.st = 7; n.lp = 1'b0; n.gp = 1'b0; n.oc = 1'b1;
            n.cause = trip ? 1 : 2;
            if (cur.count < 255) n.count = cur.count + 1;
            n.retry_age = 0;
        end
        if (n.st != 6) n.streak = 0;
        n.laser = (n.st == 6);
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '0;
        else     m <= step(m);
    end

    logic [16:0] exp_vec;
    logic [16:0] act_vec;
    assign exp_vec = {3'(m.st), m.laser, m.oc, 2'(m.cause), 8'(m.count), m.lp, m.gp};
    assign act_vec = {seq_state, laser_enable, over_current, fault_cause, fault_count,
                      dac_limit_update, dac_gain_update};

    always @(negedge clk) begin
        checks++;
        if (act_vec !== exp_vec) begin
            errors++;
            $display("FAIL model t=%0t: dut {st,en,oc,cause,cnt,lp,gp}=%h wanted %h",
                     $time, act_vec, exp_vec);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d wanted %0d", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n;
        n = 0;
        while (seq_state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (seq_state !== s) begin
            errors++;
            $display("FAIL %s: seq_state=%0d wanted %0d within %0d cycles", tag, seq_state, s, budget);
        end
    endtask

    task automatic adc(input logic [15:0] d);
        @(negedge clk);
        adc_data_valid = 1'b1;
        adc_current_data = d;
        @(negedge clk);
        adc_data_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        fault_clear = 1'b1;
        @(negedge clk);
        fault_clear = 1'b0;
    endtask

    initial begin
        int n;
        int lp0;
        int gp0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_state", seq_state, 0);
        check("reset_laser", laser_enable, 0);
        check("reset_count", fault_count, 0);
        rst = 1'b0;

        // Normal power-up
        @(negedge clk);
        enable_req = 1'b1;
        wait_state(3'd5, 100, "reach_settle");
        n = 0;
        while (!laser_enable && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("settle_cycles", n, 20);
        check("run_state", seq_state, 6);
        check("limit_pulses", lim_pulses, 1);
        check("gain_pulses", gain_pulses, 1);

        // Samples equal to the limit never trip; stray fault_clear ignored
        repeat (5) adc(16'h8000);
        pulse_clear();
        check("equal_no_trip", seq_state, 6);
        check("equal_laser", laser_enable, 1);

        // Debounce: streak broken by an in-limit sample
        adc(16'h8001); adc(16'h8001); adc(16'h8000); adc(16'h8001); adc(16'h8001);
        check("two_over_no_trip", laser_enable, 1);
        adc(16'h8001);
        check("trip_laser_off", laser_enable, 0);
        check("trip_state", seq_state, 7);
        check("trip_cause", fault_cause, 1);
        check("trip_count", fault_count, 1);
        check("trip_flag", over_current, 1);

        // Clear ignored while request held, honoured once dropped
        pulse_clear();
        @(negedge clk);
        check("clear_req_held", seq_state, 7);
        enable_req = 1'b0;
        pulse_clear();
        check("clear_idle", seq_state, 0);
        check("clear_flag", over_current, 0);

        // Trip coincident with request drop; limit lowered live
        @(negedge clk);
        enable_req = 1'b1;
        wait_state(3'd6, 100, "reach_run_2");
        @(negedge clk);
        current_limit = 16'h7FFF;
        adc(16'h8000); adc(16'h8000);
        @(negedge clk);
        adc_data_valid = 1'b1;
        adc_current_data = 16'h8000;
        enable_req = 1'b0;
        @(negedge clk);
        adc_data_valid = 1'b0;
        check("trip_vs_drop_state", seq_state, 7);
        check("trip_vs_drop_count", fault_count, 2);
        pulse_clear();
        check("clear_idle_2", seq_state, 0);
        current_limit = 16'h8000;

        // Request dropped mid-handshake
        @(negedge clk);
        enable_req = 1'b1;
        wait_state(3'd2, 20, "reach_lim_wait");
        gp0 = gain_pulses;
        enable_req = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_idle", seq_state, 0);
        check("abort_no_gain", gain_pulses - gp0, 0);

        // DAC handshake timeout
        force_busy = 1'b1;
        enable_req = 1'b1;
        lp0 = lim_pulses;
        wait_state(3'd1, 5, "reach_lim_req");
        n = 0;
        while (seq_state == 3'd1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", n, 50);
        check("timeout_state", seq_state, 7);
        check("timeout_cause", fault_cause, 2);
        check("timeout_no_pulse", lim_pulses - lp0, 0);
        force_busy = 1'b0;
        enable_req = 1'b0;
        pulse_clear();
        check("clear_idle_3", seq_state, 0);

        // Asynchronous reset in RUN
        @(negedge clk);
        enable_req = 1'b1;
        wait_state(3'd6, 100, "reach_run_3");
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_laser", laser_enable, 0);
        check("async_rst_state", seq_state, 0);
        check("async_rst_count", fault_count, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

`ifdef SEED_SEQ_AUTO_RETRY_EN
        // Four trips with request held: three retries, then stay in FAULT
        for (int k = 0; k < 4; k++) begin
            wait_state(3'd6, 300, "retry_run");
            adc(16'h9000); adc(16'h9000); adc(16'h9000);
            check("retry_trip_count", fault_count, k + 1);
        end
        repeat (100) @(negedge clk);
        check("retry_exhausted_state", seq_state, 7);
        check("retry_exhausted_count", fault_count, 4);
`else
        repeat (40) @(negedge clk);
        check("post_rst_run", seq_state, 6);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
